mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the shared cache/RAM memory path.
- Port 0 is the instruction-fetch side; port 1 is the load/store side.
- Serialises their accesses onto one memory interface with round-robin fairness, holds the memory operands stable until the memory responds, and times out stuck accesses.
- Keeps access and miss statistics sampled from the cache miss flag.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 69 ++++++
 rtl/mem_arbiter_rr_arb2.sv | 31 +++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory arbiter slice.
//   state_e      : arbiter sequencer states (IDLE, BUSY)
//   PORT0/PORT1  : encoding of the owning / last-granted requester
//   DEF_AW/DEF_DW: default address and data widths
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports, the shared memory port and the statistics
// port of the arbiter.
//   slave  : view of the arbiter (requests/responses in, grants/results out)
//   master : view of the environment driving the arbiter
// Requester signals : pN_req, pN_wr, pN_addr, pN_wdata -> pN_done, pN_err,
//                     pN_rdata (N = 0 instruction fetch, N = 1 load/store)
// Memory signals    : mem_req, mem_wr, mem_addr, mem_wdata <- mem_resp,
//                     mem_miss, mem_rdata
// Statistics        : stat_clr -> stat_acc_cnt, stat_miss_cnt
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);

    logic             p0_req;
    logic             p0_wr;
    logic [AW-1:0]    p0_addr;
    logic [DW-1:0]    p0_wdata;
    logic             p0_done;
    logic             p0_err;
    logic [DW-1:0]    p0_rdata;

    logic             p1_req;
    logic             p1_wr;
    logic [AW-1:0]    p1_addr;
    logic [DW-1:0]    p1_wdata;
    logic             p1_done;
    logic             p1_err;
    logic [DW-1:0]    p1_rdata;

    logic             mem_req;
    logic             mem_wr;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_resp;
    logic             mem_miss;
    logic [DW-1:0]    mem_rdata;

    logic             stat_clr;
    logic [CNT_W-1:0] stat_acc_cnt;
    logic [CNT_W-1:0] stat_miss_cnt;

    modport slave (
        input  p0_req, p0_wr, p0_addr, p0_wdata,
        output p0_done, p0_err, p0_rdata,
        input  p1_req, p1_wr, p1_addr, p1_wdata,
        output p1_done, p1_err, p1_rdata,
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_resp, mem_miss, mem_rdata,
        input  stat_clr,
        output stat_acc_cnt, stat_miss_cnt
    );

    modport master (
        output p0_req, p0_wr, p0_addr, p0_wdata,
        input  p0_done, p0_err, p0_rdata,
        output p1_req, p1_wr, p1_addr, p1_wdata,
        input  p1_done, p1_err, p1_rdata,
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_resp, mem_miss, mem_rdata,
        output stat_clr,
        input  stat_acc_cnt, stat_miss_cnt
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin pick.
//   req_i   : request vector, bit 0 = port 0, bit 1 = port 1
//   last_i  : port granted most recently (PORT0/PORT1)
//   valid_o : at least one request is present
//   grant_o : chosen port (PORT0/PORT1), meaningful only when valid_o=1
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       grant_o
);

    // A lone request always wins; on a tie the port that was not served
    // last goes first, which gives strict alternation under contention.
    always_comb begin
        valid_o = |req_i;
        grant_o = PORT0;
        case (req_i)
            2'b01:   grant_o = PORT0;
            2'b10:   grant_o = PORT1;
            2'b11:   grant_o = (last_i == PORT0) ? PORT1 : PORT0;
            default: grant_o = PORT0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises instruction-fetch (port 0) and load/store (port 1) accesses onto
// one memory interface with round-robin fairness, holds the memory operands
// stable until the memory responds, aborts accesses that exceed TIMEOUT cycles
// and counts completed accesses and read misses.
//   clk   : clock, all logic on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : mem_arbiter_if.slave (requester ports, memory port, statistics)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      bus
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             p0_done_q, p0_done_d;
    logic             p1_done_q, p1_done_d;
    logic             p0_err_q, p0_err_d;
    logic             p1_err_q, p1_err_d;
    logic [DW-1:0]    p0_rdata_q, p0_rdata_d;
    logic [DW-1:0]    p1_rdata_q, p1_rdata_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    logic             arb_valid;
    logic             arb_grant;

    rr_arb2 u_rr_arb2 (
        .req_i   ({bus.p1_req, bus.p0_req}),
        .last_i  (last_q),
        .valid_o (arb_valid),
        .grant_o (arb_grant)
    );

    // Next-state logic. Operands are captured once at grant and the memory
    // port is driven only from those registers, so a requester changing its
    // inputs mid-access cannot disturb the memory. A response in the same
    // cycle the timeout expires counts as a normal completion. stat_clr is
    // evaluated last so it overrides any increment on the same edge.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tmo_d      = tmo_q;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        p0_err_d   = 1'b0;
        p1_err_d   = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        acc_d      = acc_q;
        miss_d     = miss_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = BUSY;
                    owner_d = arb_grant;
                    tmo_d   = '0;
                    if (arb_grant == PORT1) begin
                        wr_d    = bus.p1_wr;
                        addr_d  = bus.p1_addr;
                        wdata_d = bus.p1_wdata;
                    end else begin
                        wr_d    = bus.p0_wr;
                        addr_d  = bus.p0_addr;
                        wdata_d = bus.p0_wdata;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_resp) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    if (owner_q == PORT1) begin
                        p1_done_d = 1'b1;
                        if (!wr_q) p1_rdata_d = bus.mem_rdata;
                    end else begin
                        p0_done_d = 1'b1;
                        if (!wr_q) p0_rdata_d = bus.mem_rdata;
                    end
                    if (acc_q != '1) acc_d = acc_q + CNT_W'(1);
                    if (!wr_q && bus.mem_miss && (miss_q != '1)) begin
                        miss_d = miss_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    if (owner_q == PORT1) p1_err_d = 1'b1;
                    else                  p0_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.stat_clr) begin
            acc_d  = '0;
            miss_d = '0;
        end
    end

    // State register. Reset abandons any access in flight; the last-grant
    // bit resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= PORT1;
            owner_q    <= PORT0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tmo_q      <= '0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            acc_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tmo_q      <= tmo_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
            p0_err_q   <= p0_err_d;
            p1_err_q   <= p1_err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            acc_q      <= acc_d;
            miss_q     <= miss_d;
        end
    end

    // All outputs come straight from registers.
    assign bus.mem_req       = (state_q == BUSY);
    assign bus.mem_wr        = wr_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.p0_done       = p0_done_q;
    assign bus.p1_done       = p1_done_q;
    assign bus.p0_err        = p0_err_q;
    assign bus.p1_err        = p1_err_q;
    assign bus.p0_rdata      = p0_rdata_q;
    assign bus.p1_rdata      = p1_rdata_q;
    assign bus.stat_acc_cnt  = acc_q;
    assign bus.stat_miss_cnt = miss_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter with TIMEOUT=8 and CNT_W=2, so timeout
// and counter saturation are reached in a few cycles. Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return every driven input to its quiet value.
    task automatic idle_inputs();
        bus.p0_req = 1'b0; bus.p0_wr = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_wr = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        bus.mem_resp = 1'b0; bus.mem_miss = 1'b0; bus.mem_rdata = '0;
        bus.stat_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Every output must come up at its reset value.
    task automatic test_reset();
        do_reset();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %0h expected 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if ({bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err} !== 4'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {bus.p0_done, bus.p1_done, bus.p0_err, bus.p1_err}); end
        checks++; if (bus.p0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_p0_rdata: got %h expected 0", bus.p0_rdata); end
        checks++; if ({bus.stat_acc_cnt, bus.stat_miss_cnt} !== 4'b0) begin errors++; $display("[TB] FAIL reset_counters: got %b expected 0000", {bus.stat_acc_cnt, bus.stat_miss_cnt}); end
    endtask

    // Single port-0 read with a miss, response in the third BUSY cycle.
    task automatic test_single_read();
        do_reset();
        bus.p0_req = 1'b1; bus.p0_wr = 1'b0; bus.p0_addr = 32'h10;
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rd_mem_req: got %0h expected 1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL rd_mem_addr: got %h expected 00000010", bus.mem_addr); end
        checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL rd_mem_wr: got %0h expected 0", bus.mem_wr); end
        tick();
        tick();
        checks++; if ({bus.mem_req, bus.p0_done} !== 2'b10) begin errors++; $display("[TB] FAIL rd_waiting: got %b expected 10", {bus.mem_req, bus.p0_done}); end
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'hDEADBEEF; bus.mem_miss = 1'b1;
        tick();
        checks++; if (bus.p0_done !== 1'b1) begin errors++; $display("[TB] FAIL rd_done: got %0h expected 1", bus.p0_done); end
        checks++; if (bus.p0_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_rdata: got %h expected deadbeef", bus.p0_rdata); end
        checks++; if (bus.stat_acc_cnt !== 2'd1) begin errors++; $display("[TB] FAIL rd_acc: got %0d expected 1", bus.stat_acc_cnt); end
        checks++; if (bus.stat_miss_cnt !== 2'd1) begin errors++; $display("[TB] FAIL rd_miss: got %0d expected 1", bus.stat_miss_cnt); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rd_mem_req_drop: got %0h expected 0", bus.mem_req); end
        idle_inputs();
        tick();
        checks++; if (bus.p0_done !== 1'b0) begin errors++; $display("[TB] FAIL rd_done_pulse: got %0h expected 0", bus.p0_done); end
        checks++; if (bus.p0_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_rdata_hold: got %h expected deadbeef", bus.p0_rdata); end
    endtask

    // Both ports request continuously with one-cycle memory: grants alternate
    // p0, p1, p0, p1; the access counter saturates at 3 after four accesses.
    task automatic test_round_robin();
        logic [AW-1:0] expAddr;
        logic [1:0]    expDone;
        logic [DW-1:0] gotData;
        do_reset();
        bus.p0_req = 1'b1; bus.p0_addr = 32'h100;
        bus.p1_req = 1'b1; bus.p1_addr = 32'h200;
        bus.mem_resp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expAddr = (i % 2 == 0) ? 32'h100 : 32'h200;
            expDone = (i % 2 == 0) ? 2'b01 : 2'b10;
            bus.mem_rdata = 32'hA0000000 + 32'(i);
            tick();
            checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rr_mem_req[%0d]: got %0h expected 1", i, bus.mem_req); end
            checks++; if (bus.mem_addr !== expAddr) begin errors++; $display("[TB] FAIL rr_addr[%0d]: got %h expected %h", i, bus.mem_addr, expAddr); end
            checks++; if ({bus.p1_done, bus.p0_done} !== 2'b00) begin errors++; $display("[TB] FAIL rr_done_busy[%0d]: got %b expected 00", i, {bus.p1_done, bus.p0_done}); end
            tick();
            checks++; if ({bus.p1_done, bus.p0_done} !== expDone) begin errors++; $display("[TB] FAIL rr_done[%0d]: got %b expected %b", i, {bus.p1_done, bus.p0_done}, expDone); end
            gotData = (i % 2 == 0) ? bus.p0_rdata : bus.p1_rdata;
            checks++; if (gotData !== 32'hA0000000 + 32'(i)) begin errors++; $display("[TB] FAIL rr_rdata[%0d]: got %h expected %h", i, gotData, 32'hA0000000 + 32'(i)); end
        end
        checks++; if (bus.stat_acc_cnt !== 2'd3) begin errors++; $display("[TB] FAIL rr_acc_sat: got %0d expected 3", bus.stat_acc_cnt); end
        checks++; if (bus.stat_miss_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rr_miss: got %0d expected 0", bus.stat_miss_cnt); end
        idle_inputs();
        tick();
    endtask

    // Port-1 write (miss flag high but never counted), then read-hit of the
    // same address. Requester operand changes during BUSY must be ignored.
    task automatic test_write_read();
        do_reset();
        bus.p1_req = 1'b1; bus.p1_wr = 1'b1; bus.p1_addr = 32'h20; bus.p1_wdata = 32'h5A5A5A5A;
        tick();
        checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("[TB] FAIL wr_mem_wr: got %0h expected 1", bus.mem_wr); end
        checks++; if (bus.mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL wr_wdata: got %h expected 5a5a5a5a", bus.mem_wdata); end
        bus.p1_addr = 32'h99; bus.p1_wdata = 32'h0; bus.p1_wr = 1'b0;
        tick();
        checks++; if ({bus.mem_addr, bus.mem_wdata, bus.mem_wr} !== {32'h20, 32'h5A5A5A5A, 1'b1}) begin errors++; $display("[TB] FAIL wr_stable: got %h %h %0h expected 00000020 5a5a5a5a 1", bus.mem_addr, bus.mem_wdata, bus.mem_wr); end
        bus.mem_resp = 1'b1; bus.mem_miss = 1'b1; bus.mem_rdata = 32'h11111111;
        tick();
        checks++; if (bus.p1_done !== 1'b1) begin errors++; $display("[TB] FAIL wr_done: got %0h expected 1", bus.p1_done); end
        checks++; if (bus.p1_rdata !== 32'h0) begin errors++; $display("[TB] FAIL wr_rdata_kept: got %h expected 0", bus.p1_rdata); end
        checks++; if (bus.stat_miss_cnt !== 2'd0) begin errors++; $display("[TB] FAIL wr_no_miss: got %0d expected 0", bus.stat_miss_cnt); end
        idle_inputs();
        tick();
        bus.p1_req = 1'b1; bus.p1_wr = 1'b0; bus.p1_addr = 32'h20;
        tick();
        checks++; if ({bus.mem_req, bus.mem_wr} !== 2'b10) begin errors++; $display("[TB] FAIL rd2_req_wr: got %b expected 10", {bus.mem_req, bus.mem_wr}); end
        bus.mem_resp = 1'b1; bus.mem_miss = 1'b0; bus.mem_rdata = 32'h5A5A5A5A;
        tick();
        checks++; if (bus.p1_rdata !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL rd2_rdata: got %h expected 5a5a5a5a", bus.p1_rdata); end
        checks++; if ({bus.stat_acc_cnt, bus.stat_miss_cnt} !== {2'd2, 2'd0}) begin errors++; $display("[TB] FAIL rd2_counters: got acc=%0d miss=%0d expected acc=2 miss=0", bus.stat_acc_cnt, bus.stat_miss_cnt); end
        idle_inputs();
        tick();
    endtask

    // Port-0 read that the memory never answers: err pulses 8 cycles after
    // mem_req rises, rdata and counters are untouched, port 1 is served next.
    task automatic test_timeout();
        do_reset();
        bus.p0_req = 1'b1; bus.p0_addr = 32'h30;
        tick();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        idle_inputs();
        tick();
        bus.p0_req = 1'b1; bus.p0_addr = 32'h40;
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) begin
            checks++; if ({bus.mem_req, bus.p0_err} !== 2'b10) begin errors++; $display("[TB] FAIL to_wait[%0d]: got %b expected 10", k, {bus.mem_req, bus.p0_err}); end
            tick();
        end
        tick();
        checks++; if (bus.p0_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got %0h expected 1", bus.p0_err); end
        checks++; if ({bus.p0_done, bus.mem_req} !== 2'b00) begin errors++; $display("[TB] FAIL to_done_req: got %b expected 00", {bus.p0_done, bus.mem_req}); end
        checks++; if (bus.p0_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL to_rdata: got %h expected 12345678", bus.p0_rdata); end
        checks++; if (bus.stat_acc_cnt !== 2'd1) begin errors++; $display("[TB] FAIL to_acc: got %0d expected 1", bus.stat_acc_cnt); end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b1; bus.p1_addr = 32'h50;
        tick();
        checks++; if ({bus.mem_req, bus.mem_addr, bus.p0_err} !== {1'b1, 32'h50, 1'b0}) begin errors++; $display("[TB] FAIL to_p1_grant: got %0h %h %0h expected 1 00000050 0", bus.mem_req, bus.mem_addr, bus.p0_err); end
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        checks++; if ({bus.p1_done, bus.p1_rdata} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("[TB] FAIL to_p1_done: got %0h %h expected 1 cafef00d", bus.p1_done, bus.p1_rdata); end
        idle_inputs();
        tick();
    endtask

    // Reset asserted during BUSY (with a response present) abandons the access.
    task automatic test_reset_mid_access();
        do_reset();
        bus.p0_req = 1'b1; bus.p0_addr = 32'h60;
        tick();
        bus.mem_resp = 1'b1;
        tick();
        idle_inputs();
        tick();
        bus.p0_req = 1'b1; bus.p0_addr = 32'h70;
        tick();
        rst_n = 1'b0; bus.mem_resp = 1'b1;
        tick();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_mem_req: got %0h expected 0", bus.mem_req); end
        checks++; if ({bus.p0_done, bus.p0_err} !== 2'b00) begin errors++; $display("[TB] FAIL rm_pulses: got %b expected 00", {bus.p0_done, bus.p0_err}); end
        checks++; if (bus.stat_acc_cnt !== 2'd0) begin errors++; $display("[TB] FAIL rm_acc: got %0d expected 0", bus.stat_acc_cnt); end
        rst_n = 1'b1;
        idle_inputs();
        tick();
        checks++; if ({bus.p0_done, bus.p0_err, bus.mem_req} !== 3'b000) begin errors++; $display("[TB] FAIL rm_after: got %b expected 000", {bus.p0_done, bus.p0_err, bus.mem_req}); end
    endtask

    // Five read-misses saturate both 2-bit counters at 3; stat_clr on the
    // same edge as a completing response leaves them at 0.
    task automatic test_saturation_clear();
        logic [CNT_W-1:0] expCnt;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            expCnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            bus.p0_req = 1'b1; bus.p0_addr = 32'(i); bus.mem_resp = 1'b1; bus.mem_miss = 1'b1;
            tick();
            tick();
            bus.p0_req = 1'b0;
            checks++; if (bus.stat_acc_cnt !== expCnt) begin errors++; $display("[TB] FAIL sat_acc[%0d]: got %0d expected %0d", i, bus.stat_acc_cnt, expCnt); end
            checks++; if (bus.stat_miss_cnt !== expCnt) begin errors++; $display("[TB] FAIL sat_miss[%0d]: got %0d expected %0d", i, bus.stat_miss_cnt, expCnt); end
            tick();
        end
        bus.p0_req = 1'b1;
        tick();
        bus.stat_clr = 1'b1;
        tick();
        checks++; if (bus.p0_done !== 1'b1) begin errors++; $display("[TB] FAIL clr_done: got %0h expected 1", bus.p0_done); end
        checks++; if ({bus.stat_acc_cnt, bus.stat_miss_cnt} !== 4'b0) begin errors++; $display("[TB] FAIL clr_counters: got acc=%0d miss=%0d expected 0 0", bus.stat_acc_cnt, bus.stat_miss_cnt); end
        idle_inputs();
        tick();
        checks++; if (bus.stat_acc_cnt !== 2'd0) begin errors++; $display("[TB] FAIL clr_hold: got %0d expected 0", bus.stat_acc_cnt); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_read();
        test_timeout();
        test_reset_mid_access();
        test_saturation_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
